ula_seq: RTL and testbench

- Sequences the ULA for multi-cycle operations. It sits between the registered ula_op from the instruction decoder and the ULA's iterative and floating-point units.
- On issue of a long-latency op it starts the selected unit, stalls fetch and decode for the op's fixed latency, then pulses the accumulator write.
- Single-cycle ops pass through with no stall.

---
 rtl/ula_seq.sv | 261 ++++++++++++++++++++++++++
 tb/tb_ula_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ula_seq.sv
// ---------------------------------------------------------------------------
// ula_seq -- ULA multi-cycle operation sequencer
//
// Sits between the registered ula_op from the instruction decoder and the
// ULA's iterative / floating-point units.
//
// Operation overview:
//   - Single-cycle ops pass straight through: acc_we is raised in the same
//     cycle and nothing stalls.
//   - Long-latency ops fire a one-cycle mc_start to the selected unit and
//     stall fetch/decode for L-1 cycles. acc_we is then pulsed in the
//     op's L-th (completion) cycle.
//   - flush aborts an op that is in flight (mc_abort), or suppresses an
//     op being issued.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous reset, active-high
//   issue      in   valid instruction presented this cycle (low on NOP)
//   ula_op     in   [5:0] registered ULA opcode
//   flush      in   abort of the in-flight op (jump/return redirect)
//   stall      out  hold PC, prefetch and decoder registers
//   mc_start   out  one-cycle start strobe to the selected multi-cycle unit
//   mc_sel     out  [2:0] unit select: 0 none, 1 MLT, 2 FADD, 3 FMLT,
//                   4 DIV, 5 FDIV, 6 CNV
//   mc_abort   out  one-cycle abort strobe to the unit
//   acc_we     out  accumulator write enable
//   busy       out  multi-cycle op in flight
//   stall_cnt  out  [15:0] saturating count of stall cycles
// ---------------------------------------------------------------------------
module ula_seq #(
    parameter int CNTW     = 6,
    parameter int MLT_LAT  = 1,
    parameter int FADD_LAT = 3,
    parameter int FMLT_LAT = 3,
    parameter int DIV_LAT  = 8,
    parameter int FDIV_LAT = 10,
    parameter int CNV_LAT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue,
    input  logic [5:0]  ula_op,
    input  logic        flush,
    output logic        stall,
    output logic        mc_start,
    output logic [2:0]  mc_sel,
    output logic        mc_abort,
    output logic        acc_we,
    output logic        busy,
    output logic [15:0] stall_cnt
);

    // -----------------------------------------------------------------------
    // Elaboration-time latency sanity checks
    // -----------------------------------------------------------------------
    // Largest latency the down-counter can hold.
    localparam int LAT_MAX = (1 << CNTW) - 1;

    if (MLT_LAT < 1 || MLT_LAT > LAT_MAX) begin : g_bad_mlt_lat
        $error("ula_seq: MLT_LAT out of range");
    end
    if (FADD_LAT < 1 || FADD_LAT > LAT_MAX) begin : g_bad_fadd_lat
        $error("ula_seq: FADD_LAT out of range");
    end
    if (FMLT_LAT < 1 || FMLT_LAT > LAT_MAX) begin : g_bad_fmlt_lat
        $error("ula_seq: FMLT_LAT out of range");
    end
    if (DIV_LAT < 1 || DIV_LAT > LAT_MAX) begin : g_bad_div_lat
        $error("ula_seq: DIV_LAT out of range");
    end
    if (FDIV_LAT < 1 || FDIV_LAT > LAT_MAX) begin : g_bad_fdiv_lat
        $error("ula_seq: FDIV_LAT out of range");
    end
    if (CNV_LAT < 1 || CNV_LAT > LAT_MAX) begin : g_bad_cnv_lat
        $error("ula_seq: CNV_LAT out of range");
    end

    // -----------------------------------------------------------------------
    // Unit select codes
    // -----------------------------------------------------------------------
    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_MLT  = 3'd1;
    localparam logic [2:0] SEL_FADD = 3'd2;
    localparam logic [2:0] SEL_FMLT = 3'd3;
    localparam logic [2:0] SEL_DIV  = 3'd4;
    localparam logic [2:0] SEL_FDIV = 3'd5;
    localparam logic [2:0] SEL_CNV  = 3'd6;

    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q,     state_d;
    logic [CNTW-1:0] cnt_q,       cnt_d;
    logic [2:0]      op_sel_q,    op_sel_d;
    logic [15:0]     stall_cnt_q, stall_cnt_d;

    // Ungated output values; everything is forced low while rst is high.
    logic       stall_c;
    logic       mc_start_c;
    logic [2:0] mc_sel_c;
    logic       mc_abort_c;
    logic       acc_we_c;
    logic       busy_c;

    // -----------------------------------------------------------------------
    // Latency / unit lookup
    // -----------------------------------------------------------------------
    // Unmapped (or unknown) opcodes fall into the default branch, which makes
    // them single-cycle with no unit selected.
    logic [2:0]      lk_sel;
    logic [CNTW-1:0] lk_lat;

    always_comb begin
        lk_sel = SEL_NONE;
        lk_lat = CNT_ONE;
        case (ula_op)
            6'd4: begin
                lk_sel = SEL_MLT;
                lk_lat = CNTW'(MLT_LAT);
            end
            6'd3: begin
                lk_sel = SEL_FADD;
                lk_lat = CNTW'(FADD_LAT);
            end
            6'd5: begin
                lk_sel = SEL_FMLT;
                lk_lat = CNTW'(FMLT_LAT);
            end
            6'd6, 6'd8: begin
                lk_sel = SEL_DIV;
                lk_lat = CNTW'(DIV_LAT);
            end
            6'd7: begin
                lk_sel = SEL_FDIV;
                lk_lat = CNTW'(FDIV_LAT);
            end
            6'd25, 6'd26, 6'd27, 6'd28: begin
                lk_sel = SEL_CNV;
                lk_lat = CNTW'(CNV_LAT);
            end
            default: begin
                lk_sel = SEL_NONE;
                lk_lat = CNT_ONE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_sel_d   = op_sel_q;
        stall_c    = 1'b0;
        mc_start_c = 1'b0;
        mc_sel_c   = SEL_NONE;
        mc_abort_c = 1'b0;
        acc_we_c   = 1'b0;
        busy_c     = 1'b0;

        case (state_q)
            IDLE: begin
                // flush only ever masks an issue here; it never raises a
                // strobe by itself.
                if (issue && !flush) begin
                    mc_sel_c = lk_sel;
                    if (lk_lat == CNT_ONE) begin
                        // Single-cycle op, including a unit whose latency
                        // is configured to 1: write back now, no start.
                        acc_we_c = 1'b1;
                    end else begin
                        // Cycle C0 of a long op; this cycle counts as the
                        // first stalled one, so L-1 cycles remain in RUN.
                        mc_start_c = 1'b1;
                        stall_c    = 1'b1;
                        cnt_d      = lk_lat - CNT_ONE;
                        op_sel_d   = lk_sel;
                        state_d    = RUN;
                    end
                end
            end

            RUN: begin
                // issue is ignored here: the decoder keeps presenting the
                // same op while stalled.
                busy_c   = 1'b1;
                mc_sel_c = op_sel_q;
                if (flush) begin
                    // Abort beats completion, so a flush in the final
                    // cycle still suppresses the accumulator write.
                    mc_abort_c = 1'b1;
                    state_d    = IDLE;
                    cnt_d      = '0;
                    op_sel_d   = SEL_NONE;
                end else if (cnt_q == CNT_ONE) begin
                    // Completion cycle: release the pipeline and write.
                    acc_we_c = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                    op_sel_d = SEL_NONE;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                op_sel_d = SEL_NONE;
            end
        endcase
    end

    // Saturating stall-cycle counter; only reset clears it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_c && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_sel_q    <= SEL_NONE;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_sel_q    <= op_sel_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: the combinational terms also depend on issue/ula_op, so they
    // are gated to keep every output low for as long as rst is held.
    // -----------------------------------------------------------------------
    assign stall     = stall_c    & ~rst;
    assign mc_start  = mc_start_c & ~rst;
    assign mc_sel    = rst ? SEL_NONE : mc_sel_c;
    assign mc_abort  = mc_abort_c & ~rst;
    assign acc_we    = acc_we_c   & ~rst;
    assign busy      = busy_c     & ~rst;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ula_seq.sv
// ---------------------------------------------------------------------------
// tb_ula_seq -- self-checking bench for ula_seq
//
// A table of per-cycle records {inputs, expected outputs} is applied in a
// loop; each expected record goes into a scoreboard queue when its inputs
// are driven and is popped and compared when the outputs are sampled on the
// falling edge. The expected stall count follows the table's own stall
// column. A hand-written sequence at the end drives the stall counter into
// saturation.
// ---------------------------------------------------------------------------
module tb_ula_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue;
    logic [5:0]  ula_op;
    logic        flush;
    logic        stall;
    logic        mc_start;
    logic [2:0]  mc_sel;
    logic        mc_abort;
    logic        acc_we;
    logic        busy;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ula_seq dut (
        .clk       (clk),
        .rst       (rst),
        .issue     (issue),
        .ula_op    (ula_op),
        .flush     (flush),
        .stall     (stall),
        .mc_start  (mc_start),
        .mc_sel    (mc_sel),
        .mc_abort  (mc_abort),
        .acc_we    (acc_we),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    typedef struct {
        logic       r;
        logic       iss;
        logic [5:0] op;
        logic       fl;
        logic       st;
        logic       ms;
        logic [2:0] sel;
        logic       ab;
        logic       we;
        logic       bz;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    task automatic add(input logic r, input logic iss, input logic [5:0] op,
                       input logic fl, input logic st, input logic ms,
                       input logic [2:0] sel, input logic ab, input logic we,
                       input logic bz);
        vec_t v;
        v.r = r;   v.iss = iss; v.op = op;   v.fl = fl;
        v.st = st; v.ms = ms;   v.sel = sel; v.ab = ab;
        v.we = we; v.bz = bz;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Idle row helper: no issue, everything expected low.
    task automatic add_idle();
        add(0, 0, 6'd0, 0, 0, 0, 3'd0, 0, 0, 0);
    endtask

    logic [15:0] exp_sc;

    initial begin
        vec_t e;
        vec_t v;

        rst    = 1'b1;
        issue  = 1'b0;
        ula_op = 6'd0;
        flush  = 1'b0;
        exp_sc = 16'd0;

        // ------------------------- vector table --------------------------
        //    r iss op  fl   st ms sel ab we bz
        // Reset: outputs low even with a DIV presented.
        add(1, 1, 6'd6, 0,  0, 0, 3'd0, 0, 0, 0);
        add(1, 0, 6'd0, 0,  0, 0, 3'd0, 0, 0, 0);
        add_idle();
        // Reset mid-op: DIV C0..C2, rst at C3, then single-cycle op 2.
        add(0, 1, 6'd6, 0,  1, 1, 3'd4, 0, 0, 0);
        add(0, 1, 6'd6, 0,  1, 0, 3'd4, 0, 0, 1);
        add(0, 1, 6'd6, 0,  1, 0, 3'd4, 0, 0, 1);
        add(1, 1, 6'd6, 0,  0, 0, 3'd0, 0, 0, 0);
        add(0, 1, 6'd2, 0,  0, 0, 3'd0, 0, 1, 0);
        // DIV timing: C0 start, C1..C6 stall+busy, C7 write.
        add(0, 1, 6'd6, 0,  1, 1, 3'd4, 0, 0, 0);
        for (int k = 1; k <= 6; k++) add(0, 1, 6'd6, 0, 1, 0, 3'd4, 0, 0, 1);
        add(0, 1, 6'd6, 0,  0, 0, 3'd4, 0, 1, 1);
        add_idle();
        // DIV via ula_op 8 (MOD) uses the same unit.
        add(0, 1, 6'd8, 0,  1, 1, 3'd4, 0, 0, 0);
        for (int k = 1; k <= 6; k++) add(0, 1, 6'd8, 0, 1, 0, 3'd4, 0, 0, 1);
        add(0, 1, 6'd8, 0,  0, 0, 3'd4, 0, 1, 1);
        // Back-to-back F_ADD then F_MLT, no idle cycle between.
        add(0, 1, 6'd3, 0,  1, 1, 3'd2, 0, 0, 0);
        add(0, 1, 6'd3, 0,  1, 0, 3'd2, 0, 0, 1);
        add(0, 1, 6'd3, 0,  0, 0, 3'd2, 0, 1, 1);
        add(0, 1, 6'd5, 0,  1, 1, 3'd3, 0, 0, 0);
        add(0, 1, 6'd5, 0,  1, 0, 3'd3, 0, 0, 1);
        add(0, 1, 6'd5, 0,  0, 0, 3'd3, 0, 1, 1);
        add_idle();
        // Single-cycle and NOP mix; MLT (latency 1) keeps its select.
        add(0, 1, 6'd1,  0, 0, 0, 3'd0, 0, 1, 0);
        add(0, 1, 6'd2,  0, 0, 0, 3'd0, 0, 1, 0);
        add(0, 1, 6'd29, 0, 0, 0, 3'd0, 0, 1, 0);
        add(0, 1, 6'd4,  0, 0, 0, 3'd1, 0, 1, 0);
        add(0, 1, 6'd63, 0, 0, 0, 3'd0, 0, 1, 0);
        add(0, 0, 6'd2,  0, 0, 0, 3'd0, 0, 0, 0);
        // Conversion op (latency 2).
        add(0, 1, 6'd27, 0, 1, 1, 3'd6, 0, 0, 0);
        add(0, 1, 6'd27, 0, 0, 0, 3'd6, 0, 1, 1);
        add_idle();
        // F_DIV flushed at C4.
        add(0, 1, 6'd7, 0,  1, 1, 3'd5, 0, 0, 0);
        for (int k = 1; k <= 3; k++) add(0, 1, 6'd7, 0, 1, 0, 3'd5, 0, 0, 1);
        add(0, 1, 6'd7, 1,  0, 0, 3'd5, 1, 0, 1);
        add_idle();
        // F_DIV flushed exactly at completion (C9): abort wins.
        add(0, 1, 6'd7, 0,  1, 1, 3'd5, 0, 0, 0);
        for (int k = 1; k <= 8; k++) add(0, 1, 6'd7, 0, 1, 0, 3'd5, 0, 0, 1);
        add(0, 1, 6'd7, 1,  0, 0, 3'd5, 1, 0, 1);
        add_idle();
        // Flush in IDLE suppresses issue (single- and multi-cycle ops).
        add(0, 1, 6'd2, 1,  0, 0, 3'd0, 0, 0, 0);
        add(0, 1, 6'd6, 1,  0, 0, 3'd0, 0, 0, 0);
        add_idle();

        // ------------------------- apply table ---------------------------
        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            v      = vecs[i];
            rst    = v.r;
            issue  = v.iss;
            ula_op = v.op;
            flush  = v.fl;
            sb.push_back(v);
            @(negedge clk);
            e = sb.pop_front();
            if (e.r) exp_sc = 16'd0;
            chk("stall",     i, {15'd0, stall},    {15'd0, e.st});
            chk("mc_start",  i, {15'd0, mc_start}, {15'd0, e.ms});
            chk("mc_sel",    i, {13'd0, mc_sel},   {13'd0, e.sel});
            chk("mc_abort",  i, {15'd0, mc_abort}, {15'd0, e.ab});
            chk("acc_we",    i, {15'd0, acc_we},   {15'd0, e.we});
            chk("busy",      i, {15'd0, busy},     {15'd0, e.bz});
            chk("stall_cnt", i, stall_cnt,         exp_sc);
            $display("row %0d: rst=%0b issue=%0b op=%0d flush=%0b -> stall=%0b start=%0b sel=%0d abort=%0b we=%0b busy=%0b cnt=%0d",
                     i, v.r, v.iss, v.op, v.fl, stall, mc_start, mc_sel,
                     mc_abort, acc_we, busy, stall_cnt);
            if (e.st && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
            @(posedge clk);
            #1;
        end

        // --------------------- stall counter saturation ------------------
        // Back-to-back F_DIV ops: 9 stalled cycles out of every 10.
        rst   = 1'b1;
        issue = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        issue  = 1'b1;
        ula_op = 6'd7;
        repeat (7281 * 10) @(posedge clk);
        #1;
        issue = 1'b0;
        @(negedge clk);
        chk("sat_before", 0, stall_cnt, 16'd65529);
        chk("sat_idle",   0, {15'd0, busy}, 16'd0);
        $display("sat phase 1: stall_cnt=%0d", stall_cnt);

        @(posedge clk);
        #1;
        issue = 1'b1;
        repeat (2 * 10) @(posedge clk);
        #1;
        issue = 1'b0;
        @(negedge clk);
        chk("sat_reached", 1, stall_cnt, 16'hFFFF);
        $display("sat phase 2: stall_cnt=%0d", stall_cnt);

        @(posedge clk);
        #1;
        issue = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        issue = 1'b0;
        @(negedge clk);
        chk("sat_hold", 2, stall_cnt, 16'hFFFF);
        chk("sat_done", 2, {15'd0, busy}, 16'd0);
        $display("sat phase 3: stall_cnt=%0d", stall_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
